load_store_unit: RTL and testbench

Translates load/store requests from the execute stage into word-aligned, byte-masked accesses on the data port of the bus controller, and returns aligned, sign- or zero-extended load data. Sits directly upstream of the bus controller's A port. Sequences the one-cycle synchronous RAM read latency with a small FSM, so the core sees a simple valid/ready request and response interface.

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into word-aligned, byte-masked
// RAM accesses. Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors.
module load_store_unit (
  input  logic        clk_A,
  input  logic        rst_A,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wmask,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [2:0]  funct3_reg;
  logic        store_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  mask_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;

  logic        req_illegal;
  logic        req_misalign;
  logic        req_err;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_mask;
  logic [1:0]  load_shift;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;
  logic        accept;

  assign accept = (state_reg == IDLE) && req_valid;

  // Request decode: legality and store lane replication.
  always_comb begin
    req_illegal  = 1'b0;
    req_misalign = 1'b0;
    lane_wdata   = req_wdata;
    lane_mask    = 4'b1111;
    if (req_store)
      req_illegal = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) && (req_funct3 != 3'b010);
    else
      req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    req_misalign = 1'b0;
`endif
    case (req_funct3[1:0])
      2'b00: begin
        lane_wdata = {4{req_wdata[7:0]}};
        lane_mask  = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        // Without trapping, a[0] is dropped so the halfword stays inside the word.
        lane_wdata = {2{req_wdata[15:0]}};
        lane_mask  = 4'b0011 << {req_addr[1], 1'b0};
      end
      default: begin
        lane_wdata = req_wdata;
        lane_mask  = 4'b1111;
      end
    endcase
    req_err = req_illegal || req_misalign;
  end

  // Load extraction from the RAM word presented during CAPTURE.
  always_comb begin
    load_shift   = (funct3_reg[1:0] == 2'b00) ? addr_reg[1:0] : {addr_reg[1], 1'b0};
    load_shifted = bus_rdata >> {load_shift, 3'b000};
    case (funct3_reg)
      3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b100:  load_ext = {24'h000000, load_shifted[7:0]};
      3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b101:  load_ext = {16'h0000, load_shifted[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk_A or negedge rst_A) begin
    if (!rst_A) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  state_next = store_reg ? RESP : CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_A or negedge rst_A) begin
    if (!rst_A) begin
      addr_reg   <= '0;
      funct3_reg <= '0;
      store_reg  <= 1'b0;
      wdata_reg  <= '0;
      mask_reg   <= '0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      if (accept) begin
        addr_reg   <= req_addr;
        funct3_reg <= req_funct3;
        store_reg  <= req_store;
        wdata_reg  <= lane_wdata;
        mask_reg   <= lane_mask;
        err_reg    <= req_err;
        rdata_reg  <= '0;
      end else if (state_reg == CAPTURE) begin
        rdata_reg <= load_ext;
      end else if ((state_reg == RESP) && rsp_ready) begin
        err_reg   <= 1'b0;
        rdata_reg <= '0;
      end
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign bus_addr  = (state_reg == IDLE) ? 32'h0 : {addr_reg[31:2], 2'b00};
  assign bus_wdata = (state_reg == IDLE) ? 32'h0 : wdata_reg;
  // Mask only in ACCESS so a stalled or erroring request can never write twice.
  assign bus_wmask = ((state_reg == ACCESS) && store_reg) ? mask_reg : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level shadow memory model,
// response scoreboard queue, and a registered-read RAM standing in for the bus controller.
module tb_load_store_unit;

  logic        clk_A = 1'b0;
  logic        rst_A = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  load_store_unit dut (
    .clk_A(clk_A), .rst_A(rst_A),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_addr(bus_addr), .bus_wmask(bus_wmask), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk_A = ~clk_A;

  // Synchronous RAM with one-cycle registered read.
  logic [31:0] ram [0:255];
  logic [31:0] ram_q;
  always @(posedge clk_A) begin
    for (int i = 0; i < 4; i++)
      if (bus_wmask[i]) ram[bus_addr[9:2]][i*8 +: 8] <= bus_wdata[i*8 +: 8];
    ram_q <= ram[bus_addr[9:2]];
  end
  assign bus_rdata = ram_q;

  int wr_count = 0;
  always @(posedge clk_A) if (bus_wmask != 4'b0000) wr_count <= wr_count + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] shadow [0:1023];
  int total = 0;
  int bad = 0;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, act, exp);
    end
  endtask

  function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic e;
    if (st) e = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    e = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'd1 && a[0]) e = 1'b1;
    if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd4:    return {24'h0, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd5:    return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int stall, input string name);
    exp_t e;
    exp_t got;
    logic [9:0]  b;
    logic [9:0]  ba;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wd;
    logic [31:0] v;
    int n;
    int wr0;
    int cyc;
    e.err = model_err(st, f3, a);
    e.lat = e.err ? 1 : (st ? 2 : 3);
    case (f3[1:0])
      2'd0:    begin b = a[9:0];             n = 1; exp_wd = {4{d[7:0]}};  end
      2'd1:    begin b = {a[9:1], 1'b0};     n = 2; exp_wd = {2{d[15:0]}}; end
      default: begin b = {a[9:2], 2'b00};    n = 4; exp_wd = d;            end
    endcase
    exp_mask = 4'b0000;
    v = 32'h0;
    for (int k = 0; k < n; k++) begin
      ba = b + 10'(k);
      if (!e.err && st) begin
        shadow[ba] = d[k*8 +: 8];
        exp_mask[ba[1:0]] = 1'b1;
      end
      v[k*8 +: 8] = shadow[ba];
    end
    e.rdata = (!e.err && !st) ? extend(f3, v) : 32'h0;
    sb_q.push_back(e);
    wr0 = wr_count;

    check_value({name, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk_A); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk_A);
      cyc++;
      if (cyc == 1 && !e.err) begin
        check_value({name, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
        check_value({name, ".bus_wmask"}, 32'(bus_wmask), st ? 32'(exp_mask) : 32'd0);
        if (st) check_value({name, ".bus_wdata"}, bus_wdata, exp_wd);
      end
      if (rsp_valid) break;
      if (cyc > 8) begin
        check_value({name, ".timeout"}, 32'(rsp_valid), 32'd1);
        break;
      end
    end
    got = sb_q.pop_front();
    check_value({name, ".latency"}, 32'(cyc), 32'(got.lat));
    check_value({name, ".rdata"}, rsp_rdata, got.rdata);
    check_value({name, ".err"}, 32'(rsp_err), 32'(got.err));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_A);
      check_value({name, ".stall_valid"}, 32'(rsp_valid), 32'd1);
      check_value({name, ".stall_ready"}, 32'(req_ready), 32'd0);
      check_value({name, ".stall_addr"}, bus_addr, e.err ? bus_addr : {a[31:2], 2'b00});
      check_value({name, ".stall_wmask"}, 32'(bus_wmask), 32'd0);
      check_value({name, ".stall_rdata"}, rsp_rdata, got.rdata);
    end
    rsp_ready = 1'b1;
    @(posedge clk_A); #1;
    rsp_ready = 1'b0;
    @(negedge clk_A);
    check_value({name, ".writes"}, 32'(wr_count - wr0), (st && !e.err) ? 32'd1 : 32'd0);
    check_value({name, ".idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;
    repeat (3) @(negedge clk_A);
    check_value("rst.req_ready", 32'(req_ready), 32'd1);
    check_value("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check_value("rst.rsp_err", 32'(rsp_err), 32'd0);
    check_value("rst.rsp_rdata", rsp_rdata, 32'd0);
    check_value("rst.bus_addr", bus_addr, 32'd0);
    check_value("rst.bus_wmask", 32'(bus_wmask), 32'd0);
    check_value("rst.bus_wdata", bus_wdata, 32'd0);
    rst_A = 1'b1;
    @(negedge clk_A);

    issue(1'b1, 3'd2, 32'h1000_0008, 32'hDEAD_BEEF, 0, "sw8");
    issue(1'b0, 3'd2, 32'h1000_0008, 32'h0, 0, "lw8");

    issue(1'b1, 3'd2, 32'h1000_0000, 32'h8001_7FFF, 0, "sw0a");
    issue(1'b0, 3'd1, 32'h1000_0002, 32'h0, 0, "lh2");
    issue(1'b0, 3'd5, 32'h1000_0002, 32'h0, 0, "lhu2");
    issue(1'b0, 3'd0, 32'h1000_0001, 32'h0, 0, "lb1");

    issue(1'b1, 3'd2, 32'h1000_0000, 32'h1122_3344, 0, "sw0b");
    issue(1'b1, 3'd0, 32'h1000_0003, 32'h0000_0080, 0, "sb3");
    issue(1'b0, 3'd0, 32'h1000_0003, 32'h0, 0, "lb3");
    issue(1'b0, 3'd4, 32'h1000_0003, 32'h0, 0, "lbu3");
    issue(1'b0, 3'd2, 32'h1000_0000, 32'h0, 0, "lw0");
    issue(1'b1, 3'd1, 32'h1000_0002, 32'h0000_A5C3, 0, "sh2");
    issue(1'b0, 3'd2, 32'h1000_0000, 32'h0, 0, "lw0h");

    issue(1'b1, 3'd2, 32'h1000_0004, 32'hCAFE_F00D, 0, "sw4");
    issue(1'b0, 3'd2, 32'h1000_0006, 32'h0, 0, "lw6");
    issue(1'b1, 3'd1, 32'h1000_0005, 32'h0000_1234, 0, "sh5");
    issue(1'b0, 3'd2, 32'h1000_0004, 32'h0, 0, "lw4");

    issue(1'b0, 3'd3, 32'h1000_0008, 32'h0, 0, "ld011");
    issue(1'b1, 3'd4, 32'h1000_0008, 32'h0000_00FF, 0, "st100");
    issue(1'b0, 3'd2, 32'h1000_0008, 32'h0, 0, "lw8b");

    issue(1'b1, 3'd2, 32'h1000_0010, 32'h0BAD_CAFE, 5, "sw_stall");
    issue(1'b0, 3'd2, 32'h1000_0010, 32'h0, 2, "lw_stall");

    // Reset asserted while a load is in CAPTURE drops it.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h1000_0008;
    @(posedge clk_A); #1;
    req_valid = 1'b0;
    @(negedge clk_A);
    @(negedge clk_A);
    rst_A = 1'b0;
    #1;
    check_value("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    check_value("midrst.req_ready", 32'(req_ready), 32'd1);
    check_value("midrst.bus_wmask", 32'(bus_wmask), 32'd0);
    check_value("midrst.bus_addr", bus_addr, 32'd0);
    @(negedge clk_A);
    check_value("midrst.rsp_valid2", 32'(rsp_valid), 32'd0);
    rst_A = 1'b1;
    @(negedge clk_A);
    issue(1'b0, 3'd2, 32'h1000_0008, 32'h0, 0, "lw_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
